// File: rtl/pong_frame_renderer.sv
// Pong video back end: sync timing, per-frame sprite shadows and pixel colour.
// Optional dashed centre net is enabled by defining PONG_CENTER_NET_EN.
module pong_frame_renderer #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int X_POS_W       = 10,
  parameter int Y_POS_W       = 10,
  parameter int PADDLE_WIDTH  = 5,
  parameter int PADDLE_HEIGHT = 60,
  parameter int BALL_SIDE     = 8,
  parameter int RGB_W         = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pix_stb_i,
  input  logic [X_POS_W-1:0] player_x_i,
  input  logic [Y_POS_W-1:0] player_y_i,
  input  logic [X_POS_W-1:0] enemy_x_i,
  input  logic [Y_POS_W-1:0] enemy_y_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  input  logic [Y_POS_W-1:0] ball_y_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               display_on_o,
  output logic [X_POS_W-1:0] pixel_x_o,
  output logic [Y_POS_W-1:0] pixel_y_o,
  output logic [RGB_W-1:0]   rgb_o,
  output logic               new_frame_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_POS_W-1:0] H_LAST     = X_POS_W'(H_TOTAL - 1);
  localparam logic [X_POS_W-1:0] H_ACT_END  = X_POS_W'(H_ACTIVE);
  localparam logic [X_POS_W-1:0] HS_START   = X_POS_W'(H_ACTIVE + H_FP);
  localparam logic [X_POS_W-1:0] HS_STOP    = X_POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_POS_W-1:0] V_LAST     = Y_POS_W'(V_TOTAL - 1);
  localparam logic [Y_POS_W-1:0] V_ACT_END  = Y_POS_W'(V_ACTIVE);
  localparam logic [Y_POS_W-1:0] VS_START   = Y_POS_W'(V_ACTIVE + V_FP);
  localparam logic [Y_POS_W-1:0] VS_STOP    = Y_POS_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [X_POS_W:0] PAD_W  = (X_POS_W + 1)'(PADDLE_WIDTH);
  localparam logic [Y_POS_W:0] PAD_H  = (Y_POS_W + 1)'(PADDLE_HEIGHT);
  localparam logic [X_POS_W:0] BALL_W = (X_POS_W + 1)'(BALL_SIDE);
  localparam logic [Y_POS_W:0] BALL_H = (Y_POS_W + 1)'(BALL_SIDE);

  logic [X_POS_W-1:0] h_cnt;
  logic [Y_POS_W-1:0] v_cnt;
  logic [X_POS_W-1:0] player_x_q, enemy_x_q, ball_x_q;
  logic [Y_POS_W-1:0] player_y_q, enemy_y_q, ball_y_q;

  logic h_last, v_last, active, hsync_n, vsync_n;
  logic sprite_hit, net_hit, capture;

  // The extra top bit keeps left+width from wrapping back to column 0.
  function automatic logic in_box(
    input logic [X_POS_W-1:0] x,
    input logic [X_POS_W-1:0] left,
    input logic [Y_POS_W-1:0] y,
    input logic [Y_POS_W-1:0] top,
    input logic [X_POS_W:0]   width,
    input logic [Y_POS_W:0]   height
  );
    logic [X_POS_W:0] xe, le;
    logic [Y_POS_W:0] ye, te;
    xe = {1'b0, x};
    le = {1'b0, left};
    ye = {1'b0, y};
    te = {1'b0, top};
    return (xe >= le) && (xe < le + width) && (ye >= te) && (ye < te + height);
  endfunction

  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);
  assign active  = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync_n = !((h_cnt >= HS_START) && (h_cnt < HS_STOP));
  assign vsync_n = !((v_cnt >= VS_START) && (v_cnt < VS_STOP));
  assign capture = (h_cnt == '0) && v_last;

  assign sprite_hit = in_box(h_cnt, player_x_q, v_cnt, player_y_q, PAD_W, PAD_H)
                   || in_box(h_cnt, enemy_x_q, v_cnt, enemy_y_q, PAD_W, PAD_H)
                   || in_box(h_cnt, ball_x_q, v_cnt, ball_y_q, BALL_W, BALL_H);

`ifdef PONG_CENTER_NET_EN
  localparam logic [X_POS_W-1:0] NET_L = X_POS_W'(H_ACTIVE / 2 - 1);
  localparam logic [X_POS_W-1:0] NET_R = X_POS_W'(H_ACTIVE / 2);
  assign net_hit = ((h_cnt == NET_L) || (h_cnt == NET_R)) && !v_cnt[3];
`else
  assign net_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_stb_i) begin
      h_cnt <= h_last ? '0 : h_cnt + X_POS_W'(1);
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + Y_POS_W'(1);
    end
  end

  // Positions are frozen for the whole visible frame so sprites never tear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      player_x_q <= '0;
      player_y_q <= '0;
      enemy_x_q  <= '0;
      enemy_y_q  <= '0;
      ball_x_q   <= '0;
      ball_y_q   <= '0;
    end else if (pix_stb_i && capture) begin
      player_x_q <= player_x_i;
      player_y_q <= player_y_i;
      enemy_x_q  <= enemy_x_i;
      enemy_y_q  <= enemy_y_i;
      ball_x_q   <= ball_x_i;
      ball_y_q   <= ball_y_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_o      <= 1'b1;
      vsync_o      <= 1'b1;
      display_on_o <= 1'b0;
      pixel_x_o    <= '0;
      pixel_y_o    <= '0;
      rgb_o        <= '0;
    end else if (pix_stb_i) begin
      hsync_o      <= hsync_n;
      vsync_o      <= vsync_n;
      display_on_o <= active;
      pixel_x_o    <= h_cnt;
      pixel_y_o    <= v_cnt;
      rgb_o        <= (active && (sprite_hit || net_hit)) ? '1 : '0;
    end
  end

  // Not gated by the strobe enable, so the pulse is one clock wide at any pixel rate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      new_frame_o <= 1'b0;
    else
      new_frame_o <= pix_stb_i && (h_cnt == '0) && (v_cnt == V_ACT_END);
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Self-checking bench for pong_frame_renderer using a shrunken raster so whole frames fit in a short run.
module tb_pong_frame_renderer;

  localparam int HA = 40, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 30, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int PW = 5, PH = 6, BS = 4;
`ifdef PONG_CENTER_NET_EN
  localparam int NET_ON = 1;
`else
  localparam int NET_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_stb = 1'b0;
  logic [9:0] player_x = '0, enemy_x = '0, ball_x = '0;
  logic [9:0] player_y = '0, enemy_y = '0, ball_y = '0;
  logic       hsync_o, vsync_o, display_on_o, new_frame_o;
  logic [9:0] pixel_x_o, pixel_y_o;
  logic [2:0] rgb_o;

  int checks = 0;
  int errors = 0;
  int hs_low = 0, vs_low = 0, nf_cnt = 0;

  pong_frame_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .X_POS_W(10), .Y_POS_W(10),
    .PADDLE_WIDTH(PW), .PADDLE_HEIGHT(PH), .BALL_SIDE(BS), .RGB_W(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pix_stb_i(pix_stb),
    .player_x_i(player_x), .player_y_i(player_y),
    .enemy_x_i(enemy_x), .enemy_y_i(enemy_y),
    .ball_x_i(ball_x), .ball_y_i(ball_y),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .display_on_o(display_on_o),
    .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .rgb_o(rgb_o),
    .new_frame_o(new_frame_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int px, input int py, input int ex, input int ey, input int bx, input int by);
    player_x = 10'(px); player_y = 10'(py);
    enemy_x  = 10'(ex); enemy_y  = 10'(ey);
    ball_x   = 10'(bx); ball_y   = 10'(by);
  endtask

  function automatic bit inBox(input int x, input int y, input int l, input int t, input int w, input int h);
    return x >= l && x < l + w && y >= t && y < t + h;
  endfunction

  // Reference model: the pixel shown after the n-th strobe since reset is raster position n.
  int  n = -1;
  int  sh_px = 0, sh_py = 0, sh_ex = 0, sh_ey = 0, sh_bx = 0, sh_by = 0;
  int  exp_hs = 1, exp_vs = 1, exp_disp = 0, exp_px = 0, exp_py = 0, exp_rgb = 0, exp_nf = 0;

  initial begin
    int  h, v;
    bit  s_rst, s_stb, act, lit;
    int  i_px, i_py, i_ex, i_ey, i_bx, i_by;
    forever begin
      @(posedge clk);
      s_rst = rst; s_stb = pix_stb;
      i_px = int'(player_x); i_py = int'(player_y);
      i_ex = int'(enemy_x);  i_ey = int'(enemy_y);
      i_bx = int'(ball_x);   i_by = int'(ball_y);
      #1;
      if (s_rst) begin
        n = -1;
        sh_px = 0; sh_py = 0; sh_ex = 0; sh_ey = 0; sh_bx = 0; sh_by = 0;
        exp_hs = 1; exp_vs = 1; exp_disp = 0; exp_px = 0; exp_py = 0; exp_rgb = 0; exp_nf = 0;
        hs_low = 0; vs_low = 0; nf_cnt = 0;
      end else begin
        if (s_stb) begin
          n++;
          h = n % HT;
          v = (n / HT) % VT;
          act = h < HA && v < VA;
          exp_hs = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
          exp_vs = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
          exp_disp = act ? 1 : 0;
          exp_px = h;
          exp_py = v;
          lit = inBox(h, v, sh_px, sh_py, PW, PH) || inBox(h, v, sh_ex, sh_ey, PW, PH)
             || inBox(h, v, sh_bx, sh_by, BS, BS)
             || (NET_ON == 1 && (h == HA / 2 - 1 || h == HA / 2) && ((v / 8) % 2 == 0));
          exp_rgb = (act && lit) ? 7 : 0;
          exp_nf = (h == 0 && v == VA) ? 1 : 0;
          if (h == 0 && v == VT - 1) begin
            sh_px = i_px; sh_py = i_py; sh_ex = i_ex; sh_ey = i_ey; sh_bx = i_bx; sh_by = i_by;
          end
          if (hsync_o == 1'b0) hs_low++;
          if (vsync_o == 1'b0) vs_low++;
        end else begin
          exp_nf = 0;
        end
        if (new_frame_o == 1'b1) nf_cnt++;
      end
      checkOutput("hsync", 32'(hsync_o), 32'(exp_hs));
      checkOutput("vsync", 32'(vsync_o), 32'(exp_vs));
      checkOutput("display_on", 32'(display_on_o), 32'(exp_disp));
      checkOutput("pixel_x", 32'(pixel_x_o), 32'(exp_px));
      checkOutput("pixel_y", 32'(pixel_y_o), 32'(exp_py));
      checkOutput("rgb", 32'(rgb_o), 32'(exp_rgb));
      checkOutput("new_frame", 32'(new_frame_o), 32'(exp_nf));
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hsync"}, 32'(hsync_o), 32'd1);
    checkOutput({tag, "_vsync"}, 32'(vsync_o), 32'd1);
    checkOutput({tag, "_display_on"}, 32'(display_on_o), 32'd0);
    checkOutput({tag, "_pixel_x"}, 32'(pixel_x_o), 32'd0);
    checkOutput({tag, "_pixel_y"}, 32'(pixel_y_o), 32'd0);
    checkOutput({tag, "_rgb"}, 32'(rgb_o), 32'd0);
    checkOutput({tag, "_new_frame"}, 32'(new_frame_o), 32'd0);
  endtask

  task automatic checkPixel(input int x, input int y, input int exp_val);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk);
      #1;
      if (int'(pixel_x_o) == x && int'(pixel_y_o) == y) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_pixel(%0d,%0d): got timeout expected pixel reached", x, y);
    end else begin
      checkOutput($sformatf("pixel(%0d,%0d)", x, y), 32'(rgb_o), 32'(exp_val));
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    pix_stb = 1'b0;
    #1;
    checkResetValues("reset");
    repeat (3) @(negedge clk);
  endtask

  task automatic checkFrameStats(input string tag);
    @(posedge clk);
    #2;
    checkOutput({tag, "_hsync_low_strobes"}, 32'(hs_low), 32'(HS * VT));
    checkOutput({tag, "_vsync_low_strobes"}, 32'(vs_low), 32'(VS * HT));
    checkOutput({tag, "_new_frame_cycles"}, 32'(nf_cnt), 32'd1);
  endtask

  int tx[15] = '{19, 9, 10, 14, 20, 13, 20, 10,  0, 38, 39, 39,  2,  7,  6};
  int ty[15] = '{ 0, 5,  5,  5,  7,  8,  8,  9, 10, 10, 15, 16, 20, 20, 25};
  int te[15] = '{ 7 * NET_ON, 0, 7, 0, 7 * NET_ON, 7, 0, 0, 0, 7, 7, 0, 7, 0, 7};

  initial begin
    #1 rst = 1'b1;

    $display("[TB] phase 1: continuous strobe, one frame");
    resetDut();
    rst = 1'b0;
    pix_stb = 1'b1;
    repeat (FRAME) @(negedge clk);
    pix_stb = 1'b0;
    checkFrameStats("cont");

    $display("[TB] phase 2: strobe every 4th cycle, one frame");
    resetDut();
    rst = 1'b0;
    for (int s = 0; s < FRAME; s++) begin
      pix_stb = 1'b1;
      @(negedge clk);
      pix_stb = 1'b0;
      repeat (3) @(negedge clk);
    end
    checkFrameStats("div4");

    $display("[TB] phase 3: sprites, clipping, shadowing");
    resetDut();
    applyStimulus(38, 10, 2, 20, 10, 5);
    rst = 1'b0;
    pix_stb = 1'b1;
    repeat (FRAME) @(negedge clk);
    ball_x = 10'd25;
    for (int k = 0; k < 15; k++)
      checkPixel(tx[k], ty[k], te[k]);
    checkPixel(10, 5, 0);
    checkPixel(25, 5, 7);
    checkPixel(29, 5, 0);
    checkPixel(28, 8, 7);

    $display("[TB] phase 4: reset mid-frame");
    repeat (37) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    pix_stb = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
